// File: rtl/rs_station.sv
// rtl/rs_station.sv - reservation station: holds dispatched ops, snoops CDBs, issues ready ops to the ALU
module rs_station #(
    parameter int RS_SIZE    = 16,
    parameter int OPENUM_LEN = 6,
    parameter int DATA_LEN   = 32,
    parameter int ADDR_LEN   = 32,
    parameter int ROB_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rollback_from_rob,
    input  logic                  en_from_dsp,
    input  logic [OPENUM_LEN-1:0] openum_from_dsp,
    input  logic [DATA_LEN-1:0]   V1_from_dsp,
    input  logic [DATA_LEN-1:0]   V2_from_dsp,
    input  logic [ROB_LEN-1:0]    Q1_from_dsp,
    input  logic [ROB_LEN-1:0]    Q2_from_dsp,
    input  logic [ADDR_LEN-1:0]   pc_from_dsp,
    input  logic [ADDR_LEN-1:0]   imm_from_dsp,
    input  logic [ROB_LEN-1:0]    rob_id_from_dsp,
    output logic                  full_to_dsp,
    input  logic                  valid_from_alu_cdb,
    input  logic [ROB_LEN-1:0]    rob_id_from_alu_cdb,
    input  logic [DATA_LEN-1:0]   result_from_alu_cdb,
    input  logic                  valid_from_lsb_cdb,
    input  logic [ROB_LEN-1:0]    rob_id_from_lsb_cdb,
    input  logic [DATA_LEN-1:0]   result_from_lsb_cdb,
    output logic                  en_to_alu,
    output logic [OPENUM_LEN-1:0] openum_to_alu,
    output logic [DATA_LEN-1:0]   V1_to_alu,
    output logic [DATA_LEN-1:0]   V2_to_alu,
    output logic [ADDR_LEN-1:0]   pc_to_alu,
    output logic [ADDR_LEN-1:0]   imm_to_alu,
    output logic [ROB_LEN-1:0]    rob_id_to_alu
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]    busy_q, busy_d;
    logic [OPENUM_LEN-1:0] op_q  [RS_SIZE];
    logic [OPENUM_LEN-1:0] op_d  [RS_SIZE];
    logic [DATA_LEN-1:0]   v1_q  [RS_SIZE];
    logic [DATA_LEN-1:0]   v1_d  [RS_SIZE];
    logic [DATA_LEN-1:0]   v2_q  [RS_SIZE];
    logic [DATA_LEN-1:0]   v2_d  [RS_SIZE];
    logic [ROB_LEN-1:0]    q1_q  [RS_SIZE];
    logic [ROB_LEN-1:0]    q1_d  [RS_SIZE];
    logic [ROB_LEN-1:0]    q2_q  [RS_SIZE];
    logic [ROB_LEN-1:0]    q2_d  [RS_SIZE];
    logic [ADDR_LEN-1:0]   pc_q  [RS_SIZE];
    logic [ADDR_LEN-1:0]   pc_d  [RS_SIZE];
    logic [ADDR_LEN-1:0]   imm_q [RS_SIZE];
    logic [ADDR_LEN-1:0]   imm_d [RS_SIZE];
    logic [ROB_LEN-1:0]    rob_q [RS_SIZE];
    logic [ROB_LEN-1:0]    rob_d [RS_SIZE];

    logic                  en_out_q, en_out_d;
    logic [OPENUM_LEN-1:0] op_out_q, op_out_d;
    logic [DATA_LEN-1:0]   v1_out_q, v1_out_d;
    logic [DATA_LEN-1:0]   v2_out_q, v2_out_d;
    logic [ADDR_LEN-1:0]   pc_out_q, pc_out_d;
    logic [ADDR_LEN-1:0]   imm_out_q, imm_out_d;
    logic [ROB_LEN-1:0]    rob_out_q, rob_out_d;

    logic                  issue_found, free_found;
    logic [IDX_W-1:0]      issue_idx, free_idx;
    logic [CNT_W-1:0]      busy_cnt;

    // Pick the lowest-index ready entry and lowest free slot from registered state; count occupancy
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        busy_cnt    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
        end
    end

    // One slot is kept spare so the dispatcher can still land an op in the cycle it sees full
    assign full_to_dsp = (busy_cnt >= CNT_W'(RS_SIZE - 1));

    // Next table state: CDB wakeups, issue release, dispatch with CDB bypass, rollback flush
    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        pc_d   = pc_q;
        imm_d  = imm_q;
        rob_d  = rob_q;

        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
                if (q1_q[i] != '0 && valid_from_alu_cdb && q1_q[i] == rob_id_from_alu_cdb) begin
                    v1_d[i] = result_from_alu_cdb;
                    q1_d[i] = '0;
                end else if (q1_q[i] != '0 && valid_from_lsb_cdb && q1_q[i] == rob_id_from_lsb_cdb) begin
                    v1_d[i] = result_from_lsb_cdb;
                    q1_d[i] = '0;
                end
                if (q2_q[i] != '0 && valid_from_alu_cdb && q2_q[i] == rob_id_from_alu_cdb) begin
                    v2_d[i] = result_from_alu_cdb;
                    q2_d[i] = '0;
                end else if (q2_q[i] != '0 && valid_from_lsb_cdb && q2_q[i] == rob_id_from_lsb_cdb) begin
                    v2_d[i] = result_from_lsb_cdb;
                    q2_d[i] = '0;
                end
            end
        end

        if (issue_found) begin
            busy_d[issue_idx] = 1'b0;
        end

        if (en_from_dsp && free_found) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = openum_from_dsp;
            pc_d[free_idx]   = pc_from_dsp;
            imm_d[free_idx]  = imm_from_dsp;
            rob_d[free_idx]  = rob_id_from_dsp;
            v1_d[free_idx]   = V1_from_dsp;
            q1_d[free_idx]   = Q1_from_dsp;
            v2_d[free_idx]   = V2_from_dsp;
            q2_d[free_idx]   = Q2_from_dsp;
            if (Q1_from_dsp != '0 && valid_from_alu_cdb && Q1_from_dsp == rob_id_from_alu_cdb) begin
                v1_d[free_idx] = result_from_alu_cdb;
                q1_d[free_idx] = '0;
            end else if (Q1_from_dsp != '0 && valid_from_lsb_cdb && Q1_from_dsp == rob_id_from_lsb_cdb) begin
                v1_d[free_idx] = result_from_lsb_cdb;
                q1_d[free_idx] = '0;
            end
            if (Q2_from_dsp != '0 && valid_from_alu_cdb && Q2_from_dsp == rob_id_from_alu_cdb) begin
                v2_d[free_idx] = result_from_alu_cdb;
                q2_d[free_idx] = '0;
            end else if (Q2_from_dsp != '0 && valid_from_lsb_cdb && Q2_from_dsp == rob_id_from_lsb_cdb) begin
                v2_d[free_idx] = result_from_lsb_cdb;
                q2_d[free_idx] = '0;
            end
        end

        if (rollback_from_rob) begin
            busy_d = '0;
        end
    end

    // Issue register: load the selected entry, otherwise hold data and drop the valid
    always_comb begin
        en_out_d  = issue_found && !rollback_from_rob;
        op_out_d  = op_out_q;
        v1_out_d  = v1_out_q;
        v2_out_d  = v2_out_q;
        pc_out_d  = pc_out_q;
        imm_out_d = imm_out_q;
        rob_out_d = rob_out_q;
        if (en_out_d) begin
            op_out_d  = op_q[issue_idx];
            v1_out_d  = v1_q[issue_idx];
            v2_out_d  = v2_q[issue_idx];
            pc_out_d  = pc_q[issue_idx];
            imm_out_d = imm_q[issue_idx];
            rob_out_d = rob_q[issue_idx];
        end
    end

    // State registers; entry payloads need no reset because busy gates them
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            en_out_q  <= 1'b0;
            op_out_q  <= '0;
            v1_out_q  <= '0;
            v2_out_q  <= '0;
            pc_out_q  <= '0;
            imm_out_q <= '0;
            rob_out_q <= '0;
        end else begin
            busy_q    <= busy_d;
            en_out_q  <= en_out_d;
            op_out_q  <= op_out_d;
            v1_out_q  <= v1_out_d;
            v2_out_q  <= v2_out_d;
            pc_out_q  <= pc_out_d;
            imm_out_q <= imm_out_d;
            rob_out_q <= rob_out_d;
        end
        op_q  <= op_d;
        v1_q  <= v1_d;
        v2_q  <= v2_d;
        q1_q  <= q1_d;
        q2_q  <= q2_d;
        pc_q  <= pc_d;
        imm_q <= imm_d;
        rob_q <= rob_d;
    end

    assign en_to_alu     = en_out_q;
    assign openum_to_alu = op_out_q;
    assign V1_to_alu     = v1_out_q;
    assign V2_to_alu     = v2_out_q;
    assign pc_to_alu     = pc_out_q;
    assign imm_to_alu    = imm_out_q;
    assign rob_id_to_alu = rob_out_q;
endmodule

// File: tb/tb_rs_station.sv
// tb/tb_rs_station.sv - scoreboard bench for rs_station
module tb_rs_station;
    logic        clk = 1'b0;
    logic        rst;
    logic        rollback_from_rob;
    logic        en_from_dsp;
    logic [5:0]  openum_from_dsp;
    logic [31:0] V1_from_dsp, V2_from_dsp;
    logic [3:0]  Q1_from_dsp, Q2_from_dsp;
    logic [31:0] pc_from_dsp, imm_from_dsp;
    logic [3:0]  rob_id_from_dsp;
    logic        full_to_dsp;
    logic        valid_from_alu_cdb;
    logic [3:0]  rob_id_from_alu_cdb;
    logic [31:0] result_from_alu_cdb;
    logic        valid_from_lsb_cdb;
    logic [3:0]  rob_id_from_lsb_cdb;
    logic [31:0] result_from_lsb_cdb;
    logic        en_to_alu;
    logic [5:0]  openum_to_alu;
    logic [31:0] V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu;
    logic [3:0]  rob_id_to_alu;

    rs_station dut (
        .clk(clk), .rst(rst), .rollback_from_rob(rollback_from_rob),
        .en_from_dsp(en_from_dsp), .openum_from_dsp(openum_from_dsp),
        .V1_from_dsp(V1_from_dsp), .V2_from_dsp(V2_from_dsp),
        .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
        .pc_from_dsp(pc_from_dsp), .imm_from_dsp(imm_from_dsp),
        .rob_id_from_dsp(rob_id_from_dsp), .full_to_dsp(full_to_dsp),
        .valid_from_alu_cdb(valid_from_alu_cdb), .rob_id_from_alu_cdb(rob_id_from_alu_cdb),
        .result_from_alu_cdb(result_from_alu_cdb),
        .valid_from_lsb_cdb(valid_from_lsb_cdb), .rob_id_from_lsb_cdb(rob_id_from_lsb_cdb),
        .result_from_lsb_cdb(result_from_lsb_cdb),
        .en_to_alu(en_to_alu), .openum_to_alu(openum_to_alu),
        .V1_to_alu(V1_to_alu), .V2_to_alu(V2_to_alu),
        .pc_to_alu(pc_to_alu), .imm_to_alu(imm_to_alu), .rob_id_to_alu(rob_id_to_alu)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int          stamp;
        logic [5:0]  op;
        logic [31:0] v1, v2, pc, imm;
        logic [3:0]  rob;
    } iss_t;
    iss_t exp_q[$];
    iss_t last;

    // Reference table: slot contents as plain variables
    bit          m_busy [16];
    logic [5:0]  m_op   [16];
    logic [31:0] m_v1   [16], m_v2 [16], m_pc [16], m_imm [16];
    logic [3:0]  m_q1   [16], m_q2 [16], m_rob [16];

    function automatic int m_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    // Return the value a tag resolves to on the buses this cycle (hit=1 if it does)
    task automatic snoop(input logic [3:0] q, output bit hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (q != 0 && valid_from_alu_cdb && q == rob_id_from_alu_cdb) begin
            hit = 1'b1; val = result_from_alu_cdb;
        end else if (q != 0 && valid_from_lsb_cdb && q == rob_id_from_lsb_cdb) begin
            hit = 1'b1; val = result_from_lsb_cdb;
        end
    endtask

    // Advance the reference by one edge using the currently driven inputs
    task automatic model_step();
        int iss = -1;
        int fr = -1;
        bit h;
        logic [31:0] v;
        iss_t e;
        for (int i = 0; i < 16; i++) begin
            if (iss < 0 && m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) iss = i;
            if (fr < 0 && !m_busy[i]) fr = i;
        end
        if (!rollback_from_rob && iss >= 0) begin
            e.stamp = cyc + 1; e.op = m_op[iss]; e.v1 = m_v1[iss]; e.v2 = m_v2[iss];
            e.pc = m_pc[iss]; e.imm = m_imm[iss]; e.rob = m_rob[iss];
            exp_q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            if (m_busy[i]) begin
                snoop(m_q1[i], h, v); if (h) begin m_q1[i] = 0; m_v1[i] = v; end
                snoop(m_q2[i], h, v); if (h) begin m_q2[i] = 0; m_v2[i] = v; end
            end
        end
        if (iss >= 0) m_busy[iss] = 1'b0;
        if (en_from_dsp && fr >= 0) begin
            m_busy[fr] = 1'b1; m_op[fr] = openum_from_dsp; m_pc[fr] = pc_from_dsp;
            m_imm[fr] = imm_from_dsp; m_rob[fr] = rob_id_from_dsp;
            m_q1[fr] = Q1_from_dsp; m_v1[fr] = V1_from_dsp;
            m_q2[fr] = Q2_from_dsp; m_v2[fr] = V2_from_dsp;
            snoop(Q1_from_dsp, h, v); if (h) begin m_q1[fr] = 0; m_v1[fr] = v; end
            snoop(Q2_from_dsp, h, v); if (h) begin m_q2[fr] = 0; m_v2[fr] = v; end
        end
        if (rollback_from_rob) foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    task automatic idle();
        rollback_from_rob = 0; en_from_dsp = 0; valid_from_alu_cdb = 0; valid_from_lsb_cdb = 0;
    endtask

    // Called while clk is low: check full, step the model, cross one edge
    task automatic tick();
        tests++;
        if (full_to_dsp !== (m_count() >= 15)) begin
            fails++;
            $display("FAIL full_to_dsp cyc=%0d got=%0b want=%0b", cyc, full_to_dsp, m_count() >= 15);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic disp(input logic [31:0] v1, input logic [31:0] v2,
                        input logic [3:0] q1, input logic [3:0] q2, input logic [3:0] rob);
        en_from_dsp = 1; openum_from_dsp = 6'($urandom); V1_from_dsp = v1; V2_from_dsp = v2;
        Q1_from_dsp = q1; Q2_from_dsp = q2; rob_id_from_dsp = rob;
        pc_from_dsp = $urandom; imm_from_dsp = $urandom;
    endtask

    task automatic alu(input logic [3:0] t, input logic [31:0] r);
        valid_from_alu_cdb = 1; rob_id_from_alu_cdb = t; result_from_alu_cdb = r;
    endtask

    task automatic lsb(input logic [3:0] t, input logic [31:0] r);
        valid_from_lsb_cdb = 1; rob_id_from_lsb_cdb = t; result_from_lsb_cdb = r;
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: after every edge compare the issue port against the scoreboard
    initial begin
        last = '{stamp: 0, op: 0, v1: 0, v2: 0, pc: 0, imm: 0, rob: 0};
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                    tests++; fails++;
                    $display("FAIL missing_issue cyc=%0d got=none want=rob%0d@%0d",
                             cyc, exp_q[0].rob, exp_q[0].stamp);
                    void'(exp_q.pop_front());
                end
                tests++;
                if (en_to_alu === 1'b1) begin
                    if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
                        fails++;
                        $display("FAIL spurious_issue cyc=%0d got=rob%0d want=none", cyc, rob_id_to_alu);
                    end else begin
                        last = exp_q.pop_front();
                        if ({openum_to_alu, V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu, rob_id_to_alu} !==
                            {last.op, last.v1, last.v2, last.pc, last.imm, last.rob}) begin
                            fails++;
                            $display("FAIL issue_data cyc=%0d got=op%0h v1=%0h v2=%0h rob%0d want=op%0h v1=%0h v2=%0h rob%0d",
                                     cyc, openum_to_alu, V1_to_alu, V2_to_alu, rob_id_to_alu,
                                     last.op, last.v1, last.v2, last.rob);
                        end
                    end
                end else if (en_to_alu !== 1'b0 ||
                             {openum_to_alu, V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu, rob_id_to_alu} !==
                             {last.op, last.v1, last.v2, last.pc, last.imm, last.rob}) begin
                    fails++;
                    $display("FAIL hold cyc=%0d got=en%0b v1=%0h rob%0d want=en0 v1=%0h rob%0d",
                             cyc, en_to_alu, V1_to_alu, rob_id_to_alu, last.v1, last.rob);
                end
            end
        end
    end

    initial begin
        logic [3:0] ta, tl;
        idle();
        openum_from_dsp = 0; V1_from_dsp = 0; V2_from_dsp = 0; Q1_from_dsp = 0; Q2_from_dsp = 0;
        pc_from_dsp = 0; imm_from_dsp = 0; rob_id_from_dsp = 0;
        rob_id_from_alu_cdb = 0; result_from_alu_cdb = 0; rob_id_from_lsb_cdb = 0; result_from_lsb_cdb = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check1("reset_en", 32'(en_to_alu), 0);
        check1("reset_full", 32'(full_to_dsp), 0);
        check1("reset_v1", V1_to_alu, 0);
        check1("reset_v2", V2_to_alu, 0);
        check1("reset_pc", pc_to_alu, 0);
        check1("reset_imm", imm_to_alu, 0);
        check1("reset_op_rob", 32'({openum_to_alu, rob_id_to_alu}), 0);
        mon_on = 1'b1;

        // Ready op issues the cycle after dispatch
        disp(5, 7, 0, 0, 2); tick(); tick(); tick();
        // Wakeup from the ALU CDB
        disp(0, 1, 3, 0, 4); tick(); tick(); alu(3, 32'h10); tick(); tick(); tick();
        // Dispatch bypass from the LSB CDB
        disp(0, 9, 5, 0, 6); lsb(5, 32'hAB); tick(); tick(); tick();
        // Fill 15 entries blocked on tag 7, then release
        for (int i = 0; i < 15; i++) begin disp(i, i, 7, 0, 4'(i + 1)); tick(); end
        check1("full_at_15", 32'(full_to_dsp), 1);
        alu(7, 32'h77); tick();
        for (int i = 0; i < 17; i++) tick();
        // Rollback with a concurrent dispatch
        for (int i = 0; i < 3; i++) begin disp(i, 0, 9, 0, 4'(i + 1)); tick(); end
        rollback_from_rob = 1; disp(1, 2, 0, 0, 8); tick();
        check1("full_after_rb", 32'(full_to_dsp), 0);
        tick(); alu(9, 1); tick(); tick();
        disp(3, 4, 0, 0, 9); tick(); tick(); tick();
        // Ordering by readiness, then by index
        disp(0, 1, 2, 0, 1); tick(); disp(2, 3, 0, 0, 3); tick(); tick(); alu(2, 32'h22); tick(); tick(); tick();
        disp(0, 0, 3, 0, 5); tick(); disp(0, 0, 0, 3, 6); tick(); lsb(3, 32'h33); tick(); tick(); tick(); tick();
        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bit heavy = (n / 500) % 2 == 1;
            if ($urandom_range(99) < (heavy ? 85 : 55) && (!full_to_dsp || $urandom_range(3) == 0))
                disp($urandom, $urandom,
                     ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'd0,
                     ($urandom_range(2) == 0) ? 4'($urandom_range(15, 1)) : 4'd0,
                     4'($urandom_range(15, 1)));
            ta = 4'($urandom_range(15, 1));
            tl = 4'($urandom_range(15, 1));
            if ($urandom_range(99) < (heavy ? 20 : 50)) alu(ta, $urandom);
            if ($urandom_range(99) < (heavy ? 15 : 40) && tl != ta) lsb(tl, $urandom);
            if ($urandom_range(99) < 2) rollback_from_rob = 1;
            tick();
        end
        rollback_from_rob = 1; tick();
        for (int i = 0; i < 5; i++) tick();
        check1("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
